// File: rtl/fifo_wpack_if.sv
// Upstream lanes plus FIFO write port seen by the write-side packer.
// master drives lanes and busy; slave is the packer.
interface fifo_wpack_if #(
    parameter int DATA  = 32,
    parameter int IN    = 4,
    parameter int WRITE = 4
);
    logic [IN-1:0]               in_v;
    logic [IN-1:0][DATA-1:0]     in_d;
    logic                        in_ready;
    logic                        busy;
    logic [WRITE-1:0]            we_;
    logic [WRITE-1:0][DATA-1:0]  wd;

    modport master (
        output in_v, in_d, busy,
        input  in_ready, we_, wd
    );

    modport slave (
        input  in_v, in_d, busy,
        output in_ready, we_, wd
    );
endinterface

// File: rtl/fifo_wpack.sv
// fifo_wpack: compacts sparse input lanes into a staging ring feeding a FIFO.
// Define WPACK_BYPASS_EN for same-cycle pass-through while the ring is empty.
module fifo_wpack #(
    parameter int DATA  = 32,
    parameter int IN    = 4,
    parameter int WRITE = 4,
    parameter int SBUF  = 8
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        flush_,
    fifo_wpack_if.slave s
);
    localparam int PW = (SBUF > 1) ? $clog2(SBUF) : 1;
    localparam int CW = $clog2(SBUF + 1);
    localparam int CN = (IN > WRITE) ? IN : WRITE;

    logic [DATA-1:0] mem_q [SBUF];
    logic [DATA-1:0] mem_d [SBUF];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [DATA-1:0] comp [CN];
    int unsigned     n_in;
    int unsigned     nb;
    int unsigned     k;
    int unsigned     nst;
    logic            byp;
    logic            acc;

    // Pointer sums never exceed 2*SBUF-1, so one subtract wraps them.
    function automatic logic [PW-1:0] wrap(input int unsigned p);
        int unsigned r;
        r = (p >= SBUF) ? p - SBUF : p;
        return PW'(r);
    endfunction

    always_comb begin
        n_in = 0;
        for (int j = 0; j < CN; j++) comp[j] = '0;
        for (int i = 0; i < IN; i++) begin
            if (s.in_v[i]) begin
                for (int j = 0; j < IN; j++) begin
                    if (j == n_in) comp[j] = s.in_d[i];
                end
                n_in = n_in + 1;
            end
        end
    end

`ifdef WPACK_BYPASS_EN
    assign byp = reset_ && flush_ && !s.busy && (count_q == '0);
`else
    assign byp = 1'b0;
`endif

    assign s.in_ready = (count_q <= CW'(SBUF - IN));
    assign acc        = s.in_ready && (|s.in_v);

    always_comb begin
        k  = 0;
        nb = 0;
        if (reset_ && flush_ && !s.busy) begin
            k = (int'(count_q) < WRITE) ? int'(count_q) : WRITE;
        end
        if (byp) begin
            nb = (n_in < WRITE) ? n_in : WRITE;
        end
    end

    always_comb begin
        for (int i = 0; i < WRITE; i++) begin
            s.wd[i]  = mem_q[wrap(int'(head_q) + i)];
            s.we_[i] = !(i < k);
            if (byp) begin
                s.wd[i]  = comp[i];
                s.we_[i] = !(i < nb);
            end
        end
    end

    // Lanes beyond the bypassed ones are appended at the tail.
    always_comb begin
        mem_d = mem_q;
        nst   = 0;
        if (acc) nst = n_in - nb;
        for (int x = 0; x < IN; x++) begin
            if (acc && flush_ && x >= nb && x < n_in) begin
                mem_d[wrap(int'(tail_q) + x - nb)] = comp[x];
            end
        end
        head_d  = wrap(int'(head_q) + k);
        tail_d  = wrap(int'(tail_q) + nst);
        count_d = CW'(int'(count_q) - k + nst);
        if (!flush_) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_fifo_wpack.sv
// Bench for fifo_wpack: queue-based reference model plus directed literals.
// Build with or without WPACK_BYPASS_EN; expectations follow the define.
module tb_fifo_wpack;
    localparam int DATA  = 32;
    localparam int IN    = 4;
    localparam int WRITE = 4;
    localparam int SBUF  = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_n;

    always #5 clk = ~clk;

    fifo_wpack_if #(.DATA(DATA), .IN(IN), .WRITE(WRITE)) bus ();

    fifo_wpack #(
        .DATA(DATA), .IN(IN), .WRITE(WRITE), .SBUF(SBUF)
    ) dut (
        .clk    (clk),
        .reset_ (rst_n),
        .flush_ (flush_n),
        .s      (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q[$];
    bit mdl_ok = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] dd(input logic [31:0] a0,
        input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic drive(input logic [3:0] v, input logic [3:0][31:0] d,
                         input logic b, input logic f, input logic r);
        @(negedge clk);
        bus.in_v = v;
        bus.in_d = d;
        bus.busy = b;
        flush_n  = f;
        rst_n    = r;
        #1;
    endtask

    task automatic idle();
        drive(4'h0, '0, 1'b0, 1'b1, 1'b1);
    endtask

    // Compare against the model, take the clock edge, advance the model.
    task automatic tick();
        logic [31:0] inl[$];
        logic [31:0] lanes[$];
        logic [3:0]  ewe;
        bit          rdy;
        int          nb;
        int          kq;
        nb = 0;
        kq = 0;
        for (int i = 0; i < IN; i++)
            if (bus.in_v[i]) inl.push_back(bus.in_d[i]);
        rdy = (q.size() <= SBUF - IN);
        if (rst_n && flush_n && !bus.busy) begin
            if (q.size() > 0) begin
                for (int i = 0; i < WRITE && i < q.size(); i++)
                    lanes.push_back(q[i]);
                kq = lanes.size();
            end
`ifdef WPACK_BYPASS_EN
            else begin
                for (int i = 0; i < WRITE && i < inl.size(); i++)
                    lanes.push_back(inl[i]);
                nb = lanes.size();
            end
`endif
        end
        if (mdl_ok) begin
            ewe = '1;
            for (int i = 0; i < lanes.size(); i++) ewe[i] = 1'b0;
            chk("in_ready", 32'(bus.in_ready), 32'(rdy));
            chk("we_", 32'(bus.we_), 32'(ewe));
            for (int i = 0; i < lanes.size(); i++)
                chk($sformatf("wd[%0d]", i), bus.wd[i], lanes[i]);
        end
        @(posedge clk);
        if (!rst_n) mdl_ok = 1;
        if (!rst_n || !flush_n) begin
            q.delete();
        end else begin
            repeat (kq) void'(q.pop_front());
            if (rdy)
                for (int i = nb; i < inl.size(); i++) q.push_back(inl[i]);
        end
    endtask

    task automatic chk_wd4(input string nm, input logic [31:0] b);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_wd%0d", nm, i), bus.wd[i], b + 32'(i));
    endtask

    task automatic fill6_then(input logic f, input logic r, input string nm);
        drive(4'hF, dd(32'h40, 32'h41, 32'h42, 32'h43), 1'b1, 1'b1, 1'b1);
        tick();
        drive(4'h3, dd(32'h44, 32'h45, 0, 0), 1'b1, 1'b1, 1'b1);
        tick();
        drive(4'hF, dd(32'h50, 32'h51, 32'h52, 32'h53), 1'b1, f, r);
        chk({nm, "_pulse_we"}, 32'(bus.we_), 32'hF);
        chk({nm, "_pulse_rdy"}, 32'(bus.in_ready), 32'h0);
        tick();
        drive(4'h0, '0, 1'b1, 1'b1, 1'b1);
        chk({nm, "_after_rdy"}, 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        chk({nm, "_after_we"}, 32'(bus.we_), 32'hF);
        tick();
    endtask

    initial begin
        bus.in_v = '0;
        bus.in_d = '0;
        bus.busy = 1'b0;
        flush_n  = 1'b1;
        rst_n    = 1'b0;

        repeat (10) begin
            drive(4'h0, '0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        idle();
        chk("rst_we", 32'(bus.we_), 32'hF);
        chk("rst_rdy", 32'(bus.in_ready), 32'h1);
        tick();

        // sparse compaction
        drive(4'b1010, dd(0, 32'hA1, 0, 32'hA3), 1'b0, 1'b1, 1'b1);
`ifdef WPACK_BYPASS_EN
        chk("sp_we", 32'(bus.we_), 32'hC);
        chk("sp_wd0", bus.wd[0], 32'hA1);
        chk("sp_wd1", bus.wd[1], 32'hA3);
        tick();
`else
        chk("sp_we0", 32'(bus.we_), 32'hF);
        tick();
        idle();
        chk("sp_we", 32'(bus.we_), 32'hC);
        chk("sp_wd0", bus.wd[0], 32'hA1);
        chk("sp_wd1", bus.wd[1], 32'hA3);
        tick();
`endif
        idle();
        chk("sp_we_after", 32'(bus.we_), 32'hF);
        chk("sp_rdy_after", 32'(bus.in_ready), 32'h1);
        tick();

        // backpressure to full
        drive(4'hF, dd(32'h10, 32'h11, 32'h12, 32'h13), 1'b1, 1'b1, 1'b1);
        tick();
        drive(4'hF, dd(32'h20, 32'h21, 32'h22, 32'h23), 1'b1, 1'b1, 1'b1);
        tick();
        drive(4'h0, '0, 1'b1, 1'b1, 1'b1);
        chk("bp_full_rdy", 32'(bus.in_ready), 32'h0);
        chk("bp_busy_we", 32'(bus.we_), 32'hF);
        tick();
        idle();
        chk("bp_c1_rdy", 32'(bus.in_ready), 32'h0);
        chk("bp_c1_we", 32'(bus.we_), 32'h0);
        chk_wd4("bp_c1", 32'h10);
        tick();
        idle();
        chk("bp_c2_we", 32'(bus.we_), 32'h0);
        chk_wd4("bp_c2", 32'h20);
        chk("bp_c2_rdy", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        chk("bp_empty_we", 32'(bus.we_), 32'hF);
        tick();

        // accept and drain in the same cycle
        drive(4'h3, dd(32'h1, 32'h2, 0, 0), 1'b1, 1'b1, 1'b1);
        tick();
        drive(4'hF, dd(32'h30, 32'h31, 32'h32, 32'h33), 1'b0, 1'b1, 1'b1);
        chk("sim_we", 32'(bus.we_), 32'hC);
        chk("sim_wd0", bus.wd[0], 32'h1);
        chk("sim_wd1", bus.wd[1], 32'h2);
        tick();
        idle();
        chk("sim2_we", 32'(bus.we_), 32'h0);
        chk_wd4("sim2", 32'h30);
        tick();
        idle();
        tick();

        fill6_then(1'b0, 1'b1, "flush");
        fill6_then(1'b1, 1'b0, "reset");

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [3:0][31:0] d;
            for (int i = 0; i < 4; i++) d[i] = $urandom;
            drive(4'($urandom), d,
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 199) != 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
